// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side byte handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_last_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    tx_valid_o;
  logic [DATA_W-1:0]       tx_data_o;
  logic                    tx_ready_i;
  logic                    tx_idle_i;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i, tx_idle_i,
    output req_ready_o, tx_valid_o, tx_data_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i, tx_idle_i,
    input  req_ready_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX byte path between N_REQ requesters.
// Optional owner-stall eviction is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic               tck,
  input  logic               rst_n,
  input  logic               enable_i,
  uart_tx_arbiter_if.slave   bus,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int IDX_W    = $clog2(N_REQ);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [N_REQ-1:0] ONE_HOT  = {{(N_REQ-1){1'b0}}, 1'b1};

  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_DRAIN = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_t;

  arb_state_t         state_r, state_s;
  logic [N_REQ-1:0]   grant_r, grant_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [IDX_W-1:0]   pick_s;
  logic               owner_valid_s;
  logic               owner_last_s;
  logic               xfer_s;
  logic               tmo_hit_s;
  logic [N_REQ-1:0]   ready_s;

  // First asserted valid strictly after the pointer, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = p;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && v[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign pick_s        = rr_pick(bus.req_valid_i, ptr_r);
  assign owner_valid_s = bus.req_valid_i[owner_r];
  assign owner_last_s  = bus.req_last_i[owner_r];
  assign xfer_s        = (state_r == ARB_OWN) && owner_valid_s && bus.tx_ready_i;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic             timeout_r;

  // Consecutive owner-stall counter; saturates by evicting rather than wrapping.
  always_comb begin
    tmo_cnt_s = '0;
    tmo_hit_s = 1'b0;
    if ((state_r == ARB_OWN) && !owner_valid_s) begin
      if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
        tmo_hit_s = 1'b1;
      end else begin
        tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
      end
    end else begin
      tmo_cnt_s = '0;
    end
  end

  // Stall counter and one-cycle eviction pulse registers.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      tmo_cnt_r <= tmo_cnt_s;
      timeout_r <= tmo_hit_s;
    end
  end

  assign timeout_o = timeout_r;
`else
  assign tmo_hit_s = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state logic: grant held from IDLE through DRAIN, released when the line goes idle.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    owner_s   = owner_r;
    ptr_s     = ptr_r;
    gap_cnt_s = gap_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (enable_i && (|bus.req_valid_i)) begin
          owner_s = pick_s;
          grant_s = ONE_HOT << pick_s;
          state_s = ARB_OWN;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_OWN: begin
        if (xfer_s && owner_last_s) begin
          ptr_s   = owner_r;
          state_s = ARB_DRAIN;
        end else if (tmo_hit_s) begin
          ptr_s   = owner_r;
          state_s = ARB_DRAIN;
        end else begin
          state_s = ARB_OWN;
        end
      end
      ARB_DRAIN: begin
        if (bus.tx_idle_i) begin
          grant_s = '0;
          if (GAP_CYCLES == 0) begin
            state_s = ARB_IDLE;
          end else begin
            state_s   = ARB_GAP;
            gap_cnt_s = GAP_LOAD;
          end
        end else begin
          state_s = ARB_DRAIN;
        end
      end
      ARB_GAP: begin
        if (gap_cnt_r == '0) begin
          state_s = ARB_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      default: begin
        state_s = ARB_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // Arbitration state registers; pointer resets so requester 0 wins first.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      grant_r   <= '0;
      owner_r   <= '0;
      ptr_r     <= IDX_W'(N_REQ - 1);
      gap_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      owner_r   <= owner_s;
      ptr_r     <= ptr_s;
      gap_cnt_r <= gap_cnt_s;
    end
  end

  // Byte path: only the owner is forwarded and acknowledged, and only while owning.
  always_comb begin
    bus.tx_valid_o = 1'b0;
    bus.tx_data_o  = '0;
    ready_s        = '0;
    if (state_r == ARB_OWN) begin
      bus.tx_valid_o   = owner_valid_s;
      bus.tx_data_o    = bus.req_data_i[owner_r*DATA_W +: DATA_W];
      ready_s[owner_r] = bus.tx_ready_i;
    end else begin
      ready_s = '0;
    end
  end

  assign bus.req_ready_o = ready_s;
  assign grant_o         = grant_r;
  assign busy_o          = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised self-checking bench for uart_tx_arbiter: requester byte queues feed the DUT and
// a packet-level round-robin model predicts the forwarded (requester, byte) stream.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int GAP = 16;

  logic         tck = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable_i = 1'b0;
  logic [N-1:0] grant_o;
  logic         busy_o;
  logic         timeout_o;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYCLES(GAP), .TIMEOUT(1024)) dut (
    .tck(tck), .rst_n(rst_n), .enable_i(enable_i), .bus(bus),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 tck = ~tck;

  int           checks = 0;
  int           failures = 0;
  logic [8:0]   pq[N][$];      // per-requester bytes, bit 8 = last
  logic [15:0]  expq[$];       // {requester, byte} expected on TX
  logic [15:0]  obsq[$];       // {requester, byte} observed on TX
  logic [N-1:0] acc = '0;
  logic [N-1:0] stall_mask = '0;
  int           rdy_mode = 0;  // 0 always ready, 1 random, 2 pattern 1,0,0,1
  int           idle_mode = 1; // 0 low, 1 high, 2 random
  int           cyc = 0;
  bit           bubbles = 1'b0;

  task automatic do_reset();
    rst_n = 1'b0;
    enable_i = 1'b0;
    bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_last_i = '0;
    bus.tx_ready_i = 1'b0; bus.tx_idle_i = 1'b0;
    for (int k = 0; k < N; k++) pq[k].delete();
    expq.delete(); obsq.delete();
    acc = '0; stall_mask = '0; bubbles = 1'b0; rdy_mode = 0; idle_mode = 1; cyc = 0;
    repeat (2) @(negedge tck);
    rst_n = 1'b1;
    enable_i = 1'b1;
  endtask

  task automatic add_packet(input int k, input int len);
    for (int i = 0; i < len; i++) pq[k].push_back({(i == len - 1), 8'($urandom)});
  endtask

  // Packet-level round robin: every queued requester is waiting; pointer starts at N-1.
  task automatic build_expected();
    logic [8:0] m[N][$];
    logic [8:0] b;
    int p, sel;
    for (int k = 0; k < N; k++) m[k] = pq[k];
    p = N - 1;
    while (1) begin
      sel = -1;
      for (int i = 1; i <= N; i++) begin
        if (sel < 0 && m[(p + i) % N].size() > 0) sel = (p + i) % N;
      end
      if (sel < 0) break;
      do begin
        b = m[sel].pop_front();
        expq.push_back({8'(sel), b[7:0]});
      end while (!b[8] && m[sel].size() > 0);
      p = sel;
    end
  endtask

  // One cycle: drive requester heads at negedge, sample at negedge+1, log transfers.
  task automatic run_cycle();
    logic [8:0] tmp;
    @(negedge tck);
    for (int k = 0; k < N; k++) if (acc[k] && pq[k].size() > 0) tmp = pq[k].pop_front();
    for (int k = 0; k < N; k++) begin
      if (pq[k].size() > 0 && !stall_mask[k] && !(bubbles && grant_o[k] && $urandom_range(0, 3) == 0)) begin
        bus.req_valid_i[k] = 1'b1;
        bus.req_data_i[k*W +: W] = pq[k][0][7:0];
        bus.req_last_i[k] = pq[k][0][8];
      end else begin
        bus.req_valid_i[k] = 1'b0;
        bus.req_data_i[k*W +: W] = W'($urandom);
        bus.req_last_i[k] = 1'($urandom);
      end
    end
    case (rdy_mode)
      0: bus.tx_ready_i = 1'b1;
      1: bus.tx_ready_i = 1'($urandom);
      default: bus.tx_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
    case (idle_mode)
      0: bus.tx_idle_i = 1'b0;
      1: bus.tx_idle_i = 1'b1;
      default: bus.tx_idle_i = ($urandom_range(0, 2) == 0);
    endcase
    cyc++;
    #1;
    acc = bus.req_ready_o & bus.req_valid_i;
    for (int k = 0; k < N; k++) if (acc[k]) obsq.push_back({8'(k), bus.tx_data_o});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable_i = 1'b1;
    bus.req_valid_i = '1; bus.tx_ready_i = 1'b1; bus.tx_idle_i = 1'b1;
    @(negedge tck); #1;
    checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    checks++; if (bus.tx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid_o); end
    checks++; if (bus.tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o); end
    do_reset();
    run_cycle();
    checks++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin failures++; $display("FAIL reset_idle: got busy=%b grant=%b expected 0/0000", busy_o, grant_o); end
  endtask

  task automatic test_single_packet();
    int gap;
    do_reset();
    idle_mode = 0;
    pq[2].push_back(9'h0A1); pq[2].push_back(9'h0A2); pq[2].push_back(9'h1A3);
    run_cycle();
    checks++; if (grant_o !== 4'b0000 || bus.tx_valid_o !== 1'b0) begin failures++; $display("FAIL sp_cycle0: got grant=%b tx_valid=%b expected 0000/0", grant_o, bus.tx_valid_o); end
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      checks++; if (grant_o !== 4'b0100) begin failures++; $display("FAIL sp_grant[%0d]: got %b expected 0100", i, grant_o); end
      checks++; if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'(8'hA1 + i)) begin failures++; $display("FAIL sp_byte[%0d]: got v=%b d=%h expected 1/%h", i, bus.tx_valid_o, bus.tx_data_o, 8'(8'hA1 + i)); end
      checks++; if (bus.req_ready_o !== 4'b0100) begin failures++; $display("FAIL sp_ready[%0d]: got %b expected 0100", i, bus.req_ready_o); end
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      checks++; if (grant_o !== 4'b0100 || busy_o !== 1'b1 || bus.tx_valid_o !== 1'b0) begin failures++; $display("FAIL sp_drain[%0d]: got grant=%b busy=%b v=%b expected 0100/1/0", i, grant_o, busy_o, bus.tx_valid_o); end
    end
    idle_mode = 1;
    run_cycle();
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (i == 0) begin
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL sp_grant_clear: got %b expected 0000", grant_o); end
      end
      if (!busy_o) break;
      gap++;
    end
    checks++; if (gap != GAP) begin failures++; $display("FAIL sp_gap: got %0d cycles expected %0d", gap, GAP); end
  endtask

  task automatic test_round_robin();
    logic [15:0] o, e;
    do_reset();
    for (int r = 0; r < 2; r++) begin add_packet(0, 1); add_packet(1, 1); add_packet(3, 1); end
    build_expected();
    for (int c = 0; c < 400 && expq.size() > 0; c++) begin
      run_cycle();
      while (obsq.size() > 0) begin
        o = obsq.pop_front(); e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        checks++; if (o !== e) begin failures++; $display("FAIL rr_stream: got %h expected %h", o, e); end
      end
    end
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL rr_done: got %0d pending expected 0", expq.size()); end
  endtask

  task automatic test_mid_packet();
    logic [15:0] o, e;
    int n1;
    bit added;
    do_reset();
    add_packet(1, 4);
    build_expected();
    n1 = 0; added = 1'b0;
    for (int c = 0; c < 300; c++) begin
      run_cycle();
      if (grant_o[1]) begin
        checks++; if (bus.req_ready_o[0] !== 1'b0) begin failures++; $display("FAIL mp_nonowner_ready: got %b expected 0", bus.req_ready_o[0]); end
      end
      while (obsq.size() > 0) begin
        o = obsq.pop_front(); e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        if (o[15:8] == 8'd1) n1++;
        checks++; if (o !== e) begin failures++; $display("FAIL mp_stream: got %h expected %h", o, e); end
      end
      if (n1 == 2 && !added) begin
        add_packet(0, 1);
        expq.push_back({8'd0, pq[0][0][7:0]});
        added = 1'b1;
      end
      if (added && expq.size() == 0) break;
    end
    checks++; if (!added || expq.size() != 0) begin failures++; $display("FAIL mp_done: got %0d pending expected 0", expq.size()); end
  endtask

  task automatic test_ready_enable();
    logic [15:0] o, e;
    int n2;
    bit added;
    do_reset();
    rdy_mode = 2;
    add_packet(2, 4);
    build_expected();
    n2 = 0; added = 1'b0;
    for (int c = 0; c < 300; c++) begin
      run_cycle();
      if (bus.tx_valid_o) begin
        checks++; if (bus.req_ready_o !== (grant_o & {N{bus.tx_ready_i}})) begin failures++; $display("FAIL re_ready_mirror: got %b expected %b", bus.req_ready_o, grant_o & {N{bus.tx_ready_i}}); end
      end
      while (obsq.size() > 0) begin
        o = obsq.pop_front(); e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        n2++;
        checks++; if (o !== e) begin failures++; $display("FAIL re_stream: got %h expected %h", o, e); end
      end
      if (n2 >= 1 && !added) begin enable_i = 1'b0; add_packet(3, 2); added = 1'b1; end
      if (added && !busy_o) break;
    end
    checks++; if (n2 != 4 || expq.size() != 0) begin failures++; $display("FAIL re_packet_done: got %0d bytes expected 4", n2); end
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin failures++; $display("FAIL re_enable_block: got grant=%b busy=%b expected 0000/0", grant_o, busy_o); end
    end
    enable_i = 1'b1;
    for (int i = 0; i < pq[3].size(); i++) expq.push_back({8'd3, pq[3][i][7:0]});
    for (int c = 0; c < 200 && expq.size() > 0; c++) begin
      run_cycle();
      while (obsq.size() > 0) begin
        o = obsq.pop_front(); e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        checks++; if (o !== e) begin failures++; $display("FAIL re_stream2: got %h expected %h", o, e); end
      end
    end
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL re_done: got %0d pending expected 0", expq.size()); end
  endtask

  task automatic test_async_reset();
    bit hit;
    do_reset();
    add_packet(0, 1); add_packet(1, 4);
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      run_cycle();
      if (grant_o == 4'b0010 && acc[1]) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL ar_setup: got no owner-1 transfer expected one"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin failures++; $display("FAIL ar_regs: got grant=%b busy=%b to=%b expected 0000/0/0", grant_o, busy_o, timeout_o); end
    checks++; if (bus.tx_valid_o !== 1'b0 || bus.tx_data_o !== 8'h00 || bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL ar_path: got v=%b d=%h rdy=%b expected 0/00/0000", bus.tx_valid_o, bus.tx_data_o, bus.req_ready_o); end
    do_reset();
    for (int k = 0; k < N; k++) add_packet(k, 1);
    run_cycle();
    run_cycle();
    checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL ar_first_grant: got %b expected 0001", grant_o); end
  endtask

  task automatic test_stall();
    do_reset();
    add_packet(3, 3);
    run_cycle();
    run_cycle();
    checks++; if (grant_o !== 4'b1000 || !acc[3]) begin failures++; $display("FAIL st_setup: got grant=%b acc=%b expected 1000/1", grant_o, acc[3]); end
    stall_mask[3] = 1'b1;
    for (int c = 0; c < 120; c++) begin
      run_cycle();
      checks++; if (grant_o !== 4'b1000 || timeout_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL st_hold[%0d]: got grant=%b to=%b busy=%b expected 1000/0/1", c, grant_o, timeout_o, busy_o); end
    end
    stall_mask[3] = 1'b0;
    for (int c = 0; c < 50 && pq[3].size() > 0; c++) run_cycle();
    checks++; if (pq[3].size() != 0) begin failures++; $display("FAIL st_resume: got %0d bytes left expected 0", pq[3].size()); end
  endtask

  task automatic test_random();
    logic [15:0] o, e;
    do_reset();
    rdy_mode = 1; idle_mode = 2; bubbles = 1'b1;
    for (int p = 0; p < 16; p++) add_packet($urandom_range(0, N - 1), $urandom_range(1, 4));
    build_expected();
    for (int c = 0; c < 4000 && expq.size() > 0; c++) begin
      run_cycle();
      checks++; if ((bus.req_ready_o & ~grant_o) !== 4'b0000) begin failures++; $display("FAIL rnd_ready_owner: got ready=%b grant=%b", bus.req_ready_o, grant_o); end
      while (obsq.size() > 0) begin
        o = obsq.pop_front(); e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        checks++; if (o !== e) begin failures++; $display("FAIL rnd_stream: got %h expected %h", o, e); end
      end
    end
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL rnd_done: got %0d pending expected 0", expq.size()); end
  endtask

  initial begin
    bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_last_i = '0;
    bus.tx_ready_i = 1'b0; bus.tx_idle_i = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_mid_packet();
    test_ready_enable();
    test_async_reset();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
